mc_control_unit: RTL and testbench

Multi-cycle MIPS-style control FSM: the initiator side of the ALU interface. Sequences fetch/decode/execute/memory/writeback for the 4-bit datapath, drives ALU_control and mux selects, and consumes the ALU zero flag for branches. Sits between the instruction register and the datapath; one instance per core.

---
 rtl/mc_pkg.sv | 48 ++++
 rtl/mc_control_unit_if.sv | 37 +++
 rtl/mc_alu_decode.sv | 26 ++
 rtl/mc_control_unit.sv | 189 ++++++++++++++++++
 tb/tb_mc_control_unit.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, opcodes,
// ALU operation codes and datapath mux select codes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_EXEC_I    = 4'd10
  } state_t;

  localparam logic [3:0] OP_R    = 4'd0;
  localparam logic [3:0] OP_LW   = 4'd1;
  localparam logic [3:0] OP_SW   = 4'd2;
  localparam logic [3:0] OP_BEQ  = 4'd3;
  localparam logic [3:0] OP_BNE  = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_SLTI = 4'd6;
  localparam logic [3:0] OP_J    = 4'd7;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_SEQ = 3'b101;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that hold a memory strobe until mem_ready.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Control-unit <-> datapath bundle: instruction fields and flags in, ALU and mux
// controls out. The control unit is the master (initiator) side.
interface mc_control_unit_if;
  logic [3:0] opcode;
  logic [2:0] funct;
  logic       zero;
  logic       mem_ready;
  logic [2:0] ALU_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_source;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       illegal_op;
  logic       mem_timeout;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output ALU_control, alu_src_a, alu_src_b, i_or_d, mem_read, mem_write,
           ir_write, pc_write, pc_source, reg_write, reg_dst, mem_to_reg,
           illegal_op, mem_timeout, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  ALU_control, alu_src_a, alu_src_b, i_or_d, mem_read, mem_write,
           ir_write, pc_write, pc_source, reg_write, reg_dst, mem_to_reg,
           illegal_op, mem_timeout, state
  );
endinterface

// File: rtl/mc_alu_decode.sv
// Combinational ALU operation select from {latched opcode, funct, state}.
// Single home for the ALU code map; zero latency.
module mc_alu_decode
  import mc_pkg::*;
(
  input  logic [3:0] i_op,
  input  logic [2:0] i_funct,
  input  state_t     i_state,
  output logic [2:0] o_alu_ctrl
);

  always_comb begin
    o_alu_ctrl = ALU_ADD;
    case (i_state)
      S_EXEC_R: begin
        // funct codes beyond seq have no ALU op; fall back to add
        if (i_funct == 3'b110 || i_funct == 3'b111) o_alu_ctrl = ALU_ADD;
        else                                        o_alu_ctrl = i_funct;
      end
      S_EXEC_I: o_alu_ctrl = (i_op == OP_SLTI) ? ALU_SLT : ALU_ADD;
      S_BRANCH: o_alu_ctrl = ALU_SUB;
      default:  o_alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle fetch/decode/execute/memory/writeback control FSM; R/I 4, LW 5, SW 4, branch/J 3 cycles
// plus memory waits (strobes held until mem_ready, bounded by MEM_WAIT_MAX). MC_PERF_CNT_EN adds instr_retired.
module mc_control_unit
  import mc_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic               clk,
  input  logic               reset,
  mc_control_unit_if.master  bus
`ifdef MC_PERF_CNT_EN
  ,
  output logic [15:0]        instr_retired
`endif
);

  localparam logic [3:0] LP_WAIT_MAX   = 4'(MEM_WAIT_MAX);
  localparam logic       LP_TIMEOUT_EN = (MEM_WAIT_MAX != 0);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_op;
  logic [3:0] r_wait_cnt;
  logic       w_timeout;
  logic [2:0] w_alu_ctrl;

  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic       w_i_or_d;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_pc_write;
  logic [1:0] w_pc_source;
  logic       w_reg_write;
  logic       w_reg_dst;
  logic       w_mem_to_reg;
  logic       w_illegal_op;

  assign w_timeout = LP_TIMEOUT_EN && is_wait_state(r_state) && !bus.mem_ready
                     && (r_wait_cnt == LP_WAIT_MAX);

  mc_alu_decode u_alu_decode (
    .i_op      (r_op),
    .i_funct   (bus.funct),
    .i_state   (r_state),
    .o_alu_ctrl(w_alu_ctrl)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (bus.mem_ready)  w_next = S_DECODE;
        else if (w_timeout) w_next = S_FETCH;
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_R:              w_next = S_EXEC_R;
          OP_LW, OP_SW:      w_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE:    w_next = S_BRANCH;
          OP_ADDI, OP_SLTI:  w_next = S_EXEC_I;
          OP_J:              w_next = S_JUMP;
          default:           w_next = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  w_next = (r_op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: begin
        if (bus.mem_ready)  w_next = S_MEM_WB;
        else if (w_timeout) w_next = S_FETCH;
      end
      S_MEM_WRITE: begin
        if (bus.mem_ready || w_timeout) w_next = S_FETCH;
      end
      S_EXEC_R, S_EXEC_I: w_next = S_ALU_WB;
      default:            w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_op       <= 4'd0;
      r_wait_cnt <= 4'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op <= bus.opcode;
      // Counts only stalled cycles; any exit (completion or timeout) restarts it
      if (is_wait_state(r_state) && !bus.mem_ready && !w_timeout)
        r_wait_cnt <= (r_wait_cnt == 4'hF) ? 4'hF : r_wait_cnt + 4'd1;
      else
        r_wait_cnt <= 4'd0;
    end
  end

  always_comb begin
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = SRCB_REG;
    w_i_or_d     = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_source  = PCSRC_ALU;
    w_reg_write  = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_illegal_op = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          w_alu_src_b = SRCB_ONE;
          w_mem_read  = !w_timeout;
          w_ir_write  = bus.mem_ready;
          w_pc_write  = bus.mem_ready;
        end
        S_DECODE: begin
          w_alu_src_b  = SRCB_IMM;
          w_illegal_op = bus.opcode[3];
        end
        S_MEM_ADDR, S_EXEC_I: begin
          w_alu_src_a = 1'b1;
          w_alu_src_b = SRCB_IMM;
        end
        S_EXEC_R: w_alu_src_a = 1'b1;
        S_MEM_READ: begin
          w_i_or_d   = 1'b1;
          w_mem_read = !w_timeout;
        end
        S_MEM_WRITE: begin
          w_i_or_d    = 1'b1;
          w_mem_write = !w_timeout;
        end
        S_MEM_WB: begin
          w_reg_write  = 1'b1;
          w_mem_to_reg = 1'b1;
        end
        S_ALU_WB: begin
          w_reg_write = 1'b1;
          w_reg_dst   = (r_op == OP_R);
        end
        S_BRANCH: begin
          w_alu_src_a = 1'b1;
          w_pc_source = PCSRC_ALUOUT;
          w_pc_write  = (r_op == OP_BEQ) ? bus.zero : !bus.zero;
        end
        S_JUMP: begin
          w_pc_source = PCSRC_JUMP;
          w_pc_write  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ALU_control = reset ? ALU_ADD : w_alu_ctrl;
  assign bus.alu_src_a   = w_alu_src_a;
  assign bus.alu_src_b   = w_alu_src_b;
  assign bus.i_or_d      = w_i_or_d;
  assign bus.mem_read    = w_mem_read;
  assign bus.mem_write   = w_mem_write;
  assign bus.ir_write    = w_ir_write;
  assign bus.pc_write    = w_pc_write;
  assign bus.pc_source   = w_pc_source;
  assign bus.reg_write   = w_reg_write;
  assign bus.reg_dst     = w_reg_dst;
  assign bus.mem_to_reg  = w_mem_to_reg;
  assign bus.illegal_op  = w_illegal_op;
  assign bus.mem_timeout = reset ? 1'b0 : w_timeout;
  assign bus.state       = reset ? 4'(S_FETCH) : 4'(r_state);

`ifdef MC_PERF_CNT_EN
  logic [15:0] r_instr_retired;
  logic        w_retire;

  // Illegal and timeout exits never pass through these states with completion
  assign w_retire = (r_state == S_ALU_WB) || (r_state == S_MEM_WB) ||
                    (r_state == S_BRANCH) || (r_state == S_JUMP) ||
                    ((r_state == S_MEM_WRITE) && bus.mem_ready);

  always_ff @(posedge clk) begin
    if (reset)         r_instr_retired <= 16'd0;
    else if (w_retire) r_instr_retired <= r_instr_retired + 16'd1;
  end

  assign instr_retired = reset ? 16'd0 : r_instr_retired;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed-vector bench for mc_control_unit (MEM_WAIT_MAX = 15).
module tb_mc_control_unit;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  mc_control_unit_if bus_if ();

`ifdef MC_PERF_CNT_EN
  logic [15:0] instr_retired;
  mc_control_unit #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .reset(reset), .bus(bus_if), .instr_retired(instr_retired));
`else
  mc_control_unit #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .reset(reset), .bus(bus_if));
`endif

  always #5 clk = ~clk;

  logic [21:0] all_outs;
  assign all_outs = {bus_if.ALU_control, bus_if.alu_src_a, bus_if.alu_src_b, bus_if.i_or_d,
                     bus_if.mem_read, bus_if.mem_write, bus_if.ir_write, bus_if.pc_write,
                     bus_if.pc_source, bus_if.reg_write, bus_if.reg_dst, bus_if.mem_to_reg,
                     bus_if.illegal_op, bus_if.mem_timeout, bus_if.state};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [21:0] obs, input logic [21:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus_if.opcode = 4'd0; bus_if.funct = 3'd0; bus_if.zero = 1'b0; bus_if.mem_ready = 1'b1;
    tick(); tick();
    chk("reset_all_outs", all_outs, 22'd0);
`ifdef MC_PERF_CNT_EN
    chk("reset_retired", 22'(instr_retired), 22'd0);
`endif

    // R-type sub, memory always ready
    reset = 1'b0; bus_if.funct = 3'b001; #1;
    chk("r_fetch", {bus_if.state, bus_if.mem_read, bus_if.ir_write, bus_if.pc_write,
                    bus_if.alu_src_b, bus_if.i_or_d, bus_if.pc_source}, {4'd0, 3'b111, 2'b01, 1'b0, 2'b00});
    tick();
    chk("r_decode", {bus_if.state, bus_if.alu_src_a, bus_if.alu_src_b}, {4'd1, 1'b0, 2'b10});
    tick();
    chk("r_exec", {bus_if.state, bus_if.ALU_control, bus_if.alu_src_a, bus_if.alu_src_b},
        {4'd6, 3'b001, 1'b1, 2'b00});
    tick();
    chk("r_wb", {bus_if.state, bus_if.reg_write, bus_if.reg_dst, bus_if.mem_to_reg}, {4'd7, 3'b110});
    tick();
    chk("r_back_fetch", 22'(bus_if.state), 22'd0);

    // LW with 3 wait cycles on each access
    bus_if.opcode = 4'd1; bus_if.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lw_fetch_wait", {bus_if.state, bus_if.mem_read, bus_if.ir_write}, {4'd0, 2'b10});
      tick();
    end
    bus_if.mem_ready = 1'b1; #1;
    chk("lw_fetch_done", {bus_if.state, bus_if.mem_read, bus_if.ir_write}, {4'd0, 2'b11});
    tick();
    chk("lw_decode", 22'(bus_if.state), 22'd1);
    tick();
    chk("lw_addr", {bus_if.state, bus_if.alu_src_a, bus_if.alu_src_b}, {4'd2, 1'b1, 2'b10});
    bus_if.mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("lw_read_wait", {bus_if.state, bus_if.i_or_d, bus_if.mem_read}, {4'd3, 2'b11});
      tick();
    end
    bus_if.mem_ready = 1'b1; #1;
    chk("lw_read_done", {bus_if.state, bus_if.i_or_d, bus_if.mem_read}, {4'd3, 2'b11});
    tick();
    chk("lw_wb", {bus_if.state, bus_if.reg_write, bus_if.mem_to_reg, bus_if.reg_dst}, {4'd4, 3'b110});
    tick();
    chk("lw_back_fetch", 22'(bus_if.state), 22'd0);

    // BEQ taken
    bus_if.opcode = 4'd3; bus_if.zero = 1'b1;
    tick(); tick();
    chk("beq_z1", {bus_if.state, bus_if.pc_write, bus_if.pc_source, bus_if.ALU_control},
        {4'd8, 1'b1, 2'b01, 3'b001});
    tick();

    // BNE: zero=1 not taken, zero=0 taken within the same BRANCH cycle
    bus_if.opcode = 4'd4;
    tick(); tick();
    chk("bne_z1", {bus_if.state, bus_if.pc_write}, {4'd8, 1'b0});
    bus_if.zero = 1'b0; #1;
    chk("bne_z0", {bus_if.state, bus_if.pc_write, bus_if.pc_source}, {4'd8, 1'b1, 2'b01});
    tick();
    chk("bne_back_fetch", 22'(bus_if.state), 22'd0);

    // SLTI
    bus_if.opcode = 4'd6;
    tick(); tick();
    chk("slti_exec", {bus_if.state, bus_if.ALU_control, bus_if.alu_src_a, bus_if.alu_src_b},
        {4'd10, 3'b100, 1'b1, 2'b10});
    tick();
    chk("slti_wb", {bus_if.state, bus_if.reg_write, bus_if.reg_dst}, {4'd7, 2'b10});
    tick();

    // J
    bus_if.opcode = 4'd7;
    tick(); tick();
    chk("jump", {bus_if.state, bus_if.pc_write, bus_if.pc_source}, {4'd9, 1'b1, 2'b10});
    tick();

    // Illegal opcode 4'hC
    bus_if.opcode = 4'hC; #1;
    chk("ill_fetch", {bus_if.state, bus_if.reg_write, bus_if.mem_write}, {4'd0, 2'b00});
    tick();
    chk("ill_decode", {bus_if.state, bus_if.illegal_op, bus_if.reg_write, bus_if.mem_write},
        {4'd1, 3'b100});
    tick();
    chk("ill_back_fetch", {bus_if.state, bus_if.illegal_op, bus_if.reg_write, bus_if.mem_write},
        {4'd0, 3'b000});

    // SW: memory never ready -> timeout after 15 stalled cycles
    bus_if.opcode = 4'd2;
    tick(); tick();
    chk("sw_addr", 22'(bus_if.state), 22'd2);
    bus_if.mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) begin
      chk("sw_wait", {bus_if.state, bus_if.mem_write, bus_if.i_or_d, bus_if.mem_timeout},
          {4'd5, 3'b110});
      tick();
    end
    chk("sw_timeout", {bus_if.state, bus_if.mem_write, bus_if.mem_timeout, bus_if.pc_write,
                       bus_if.ir_write}, {4'd5, 4'b0100});
    tick();
    chk("sw_to_fetch", {bus_if.state, bus_if.mem_timeout}, {4'd0, 1'b0});

    // SW: ready arrives on the limit cycle -> completes, no timeout
    bus_if.mem_ready = 1'b1;
    tick(); tick();
    bus_if.mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) tick();
    bus_if.mem_ready = 1'b1; #1;
    chk("sw_limit_ready", {bus_if.state, bus_if.mem_write, bus_if.mem_timeout}, {4'd5, 2'b10});
    tick();
    chk("sw_limit_fetch", {bus_if.state, bus_if.mem_timeout}, {4'd0, 1'b0});
`ifdef MC_PERF_CNT_EN
    // R, LW, BEQ, BNE, SLTI, J, SW retired; illegal and timed-out SW not
    chk("retired_count", 22'(instr_retired), 22'd7);
`endif

    // Reset asserted mid-access in MEM_READ
    bus_if.opcode = 4'd1;
    tick(); tick();
    bus_if.mem_ready = 1'b0;
    tick();
    chk("rst_mid_state", 22'(bus_if.state), 22'd3);
    reset = 1'b1; #1;
    chk("rst_mid_comb", all_outs, 22'd0);
    tick();
    chk("rst_mid_next", all_outs, 22'd0);
`ifdef MC_PERF_CNT_EN
    chk("retired_cleared", 22'(instr_retired), 22'd0);
`endif
    reset = 1'b0; #1;
    chk("post_rst_fetch", {bus_if.state, bus_if.mem_read, bus_if.i_or_d}, {4'd0, 2'b10});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
